mxint8_block_packer: RTL and testbench

MXINT8_BLOCK_PACKER -- requirements
Module: mxint8_block_packer

---
 rtl/mxint8_block_packer_pkg.sv | 19 +
 rtl/mxint8_block_packer.sv | 55 +++++
 tb/tb_mxint8_block_packer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mxint8_block_packer_pkg.sv
// mxint8_block_packer_pkg: shared mxint8 widths, block size and packer FSM encodings
`ifndef MXINT8_DEFINES_SVH
`define MXINT8_DEFINES_SVH
`define MXINT8_ELEMENT_WIDTH 8
`define MXINT8_SCALE_WIDTH 8
`define BLOCK_SIZE 32
`define MXINT8_PACKER_COLLECT 1'b0
`define MXINT8_PACKER_HOLD 1'b1
`endif
package mxint8_block_packer_pkg;
  localparam int ELEM_W = `MXINT8_ELEMENT_WIDTH;
  localparam int SCALE_W = `MXINT8_SCALE_WIDTH;
  localparam int BLOCK_SIZE = `BLOCK_SIZE;
  localparam int CNT_W = $clog2(BLOCK_SIZE);
  typedef enum logic {
    COLLECT = `MXINT8_PACKER_COLLECT,
    HOLD = `MXINT8_PACKER_HOLD
  } state_e;
endpackage

// File: rtl/mxint8_block_packer.sv
// mxint8_block_packer: gathers 32 element beats plus a shared E8M0 scale into one MXINT8 block
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid/o_ready              input beat handshake (element + scale)
//   i_mxint8_element/scale       beat payload; scale only sampled on the first beat
//   o_valid/i_ready              output block handshake
//   o_mxint8_scale/elements      held block, element 0 = first beat
//   o_busy                       partial block present
module mxint8_block_packer
  import mxint8_block_packer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ELEM_W-1:0]  i_mxint8_element,
  input  logic [SCALE_W-1:0] i_mxint8_scale,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [SCALE_W-1:0] o_mxint8_scale,
  output logic [ELEM_W-1:0]  o_mxint8_elements [BLOCK_SIZE],
  output logic               o_busy
);
  state_e state_q;
  logic [CNT_W-1:0] count_q;
  logic [SCALE_W-1:0] scale_q;
  logic [ELEM_W-1:0] slot_q [BLOCK_SIZE];
  logic beat;
  assign beat = i_valid && o_ready;
  // count wraps 31 -> 0 on the completing beat purely through 5-bit overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      scale_q <= '0;
    end else if (beat) begin
      count_q <= count_q + 1'b1;
      if (count_q == '0) scale_q <= i_mxint8_scale;
      if (count_q == CNT_W'(BLOCK_SIZE - 1)) state_q <= HOLD;
    end else if (state_q == HOLD && i_ready) begin
      state_q <= COLLECT;
    end
  end
  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_slot
    always_ff @(posedge i_clk) begin
      if (i_rst) slot_q[k] <= '0;
      else if (beat && count_q == CNT_W'(k)) slot_q[k] <= i_mxint8_element;
    end
  end
  assign o_ready = state_q == COLLECT;
  assign o_valid = state_q == HOLD;
  assign o_busy = state_q == COLLECT && count_q != '0;
  assign o_mxint8_scale = scale_q;
  assign o_mxint8_elements = slot_q;
endmodule

// File: tb/tb_mxint8_block_packer.sv
// tb_mxint8_block_packer: directed/randomized self-checking bench for mxint8_block_packer
module tb_mxint8_block_packer;
  logic clk = 1'b0;
  logic rst, i_valid, i_ready;
  logic [7:0] elem, scale;
  logic o_ready, o_valid, o_busy;
  logic [7:0] o_scale;
  logic [7:0] o_elems [32];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t1, t2;
  logic [7:0] blk_e [32];
  logic [7:0] q_e [$];
  logic [7:0] q_s [$];

  mxint8_block_packer dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mxint8_element(elem), .i_mxint8_scale(scale), .o_valid(o_valid),
    .i_ready(i_ready), .o_mxint8_scale(o_scale), .o_mxint8_elements(o_elems),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one accepted beat; the model records every beat the DUT is known to take
  task automatic beat(input logic [7:0] e, input logic [7:0] s);
    int t = 0;
    i_valid = 1'b1;
    elem = e;
    scale = s;
    while (o_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    i_valid = 1'b0;
    q_e.push_back(e);
    q_s.push_back(s);
  endtask

  // expected block: elements in arrival order, scale from the first beat
  task automatic check_block(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_scale"}, 32'(o_scale), 32'(q_s[0]));
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s_e%0d", tag, k), 32'(o_elems[k]), 32'(q_e[k]));
  endtask

  task automatic send_block(input string tag, input bit gaps, input logic [7:0] s0, input logic [7:0] s1);
    q_e.delete();
    q_s.delete();
    for (int k = 0; k < 32; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        i_ready = 1'($urandom);
        @(negedge clk);
      end
      beat(blk_e[k], k == 0 ? s0 : s1);
      if (k < 31) begin
        chk($sformatf("%s_early_valid%0d", tag, k), 32'(o_valid), 32'd0);
        chk($sformatf("%s_busy%0d", tag, k), 32'(o_busy), 32'd1);
      end
    end
    check_block(tag);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    elem = '0;
    scale = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_scale", 32'(o_scale), 32'd0);
    for (int k = 0; k < 32; k++) chk($sformatf("rst_e%0d", k), 32'(o_elems[k]), 32'd0);

    // basic block, downstream always ready: o_valid for exactly one cycle
    i_ready = 1'b1;
    for (int k = 0; k < 32; k++) blk_e[k] = 8'(k);
    send_block("basic", 1'b0, 8'h7F, 8'h7F);
    chk("basic_scale7f", 32'(o_scale), 32'h7F);
    @(negedge clk);
    chk("basic_valid_drop", 32'(o_valid), 32'd0);
    chk("basic_ready_back", 32'(o_ready), 32'd1);

    // scale sampled on beat 0 only, then 10 cycles of backpressure with noise on the input
    i_ready = 1'b0;
    for (int k = 0; k < 32; k++) blk_e[k] = 8'($urandom);
    send_block("scale", 1'b0, 8'h10, 8'hFF);
    chk("scale_first_beat", 32'(o_scale), 32'h10);
    repeat (10) begin
      i_valid = 1'b1;
      elem = 8'($urandom);
      scale = 8'($urandom);
      @(negedge clk);
      check_block("hold");
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(o_valid), 32'd0);
    chk("release_ready", 32'(o_ready), 32'd1);
    chk("release_busy", 32'(o_busy), 32'd0);

    // gapped input with random i_ready during collect
    for (int k = 0; k < 32; k++) blk_e[k] = 8'h80 + 8'(k);
    send_block("gap", 1'b1, 8'($urandom), 8'($urandom));
    chk("gap_first", 32'(o_elems[0]), 32'h80);
    chk("gap_last", 32'(o_elems[31]), 32'h9F);
    i_ready = 1'b1;
    @(negedge clk);
    chk("gap_release", 32'(o_ready), 32'd1);

    // reset after 17 beats, colliding with an input beat
    for (int k = 0; k < 17; k++) beat(8'($urandom), 8'($urandom));
    chk("mid_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    i_valid = 1'b1;
    elem = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b0;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_scale", 32'(o_scale), 32'd0);
    chk("mid_rst_e0", 32'(o_elems[0]), 32'd0);
    for (int k = 0; k < 32; k++) blk_e[k] = 8'hAA;
    send_block("aa", 1'b0, 8'h5A, 8'h5A);
    @(negedge clk);

    // back-to-back blocks: completions 33 cycles apart
    i_ready = 1'b1;
    for (int k = 0; k < 32; k++) blk_e[k] = 8'($urandom);
    send_block("b2b1", 1'b0, 8'($urandom), 8'($urandom));
    t1 = cyc;
    for (int k = 0; k < 32; k++) blk_e[k] = 8'($urandom);
    send_block("b2b2", 1'b0, 8'($urandom), 8'($urandom));
    t2 = cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
